// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: joystick bit layout,
// coin FSM states, counter widths and the pending-coin arithmetic.
package arcade_input_pkg;

    localparam int JOY_W      = 16;
    localparam int BIT_R      = 0;
    localparam int BIT_L      = 1;
    localparam int BIT_D      = 2;
    localparam int BIT_U      = 3;
    localparam int BIT_FIRE   = 4;
    localparam int BIT_START0 = 5;
    localparam int BIT_COIN   = 9;

    localparam int PEND_W     = 3;
    localparam int REQ_W      = 3;
    localparam int COIN_CNT_W = 16;
    localparam int AF_CNT_W   = 20;

    localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

    typedef enum logic [1:0] {
        COIN_IDLE = 2'd0,
        COIN_HI   = 2'd1,
        COIN_GAP  = 2'd2
    } coin_state_t;

    // Adds new requests and removes the coin being issued before clamping,
    // so a full counter that issues and receives in one cycle stays exact.
    function automatic logic [PEND_W-1:0] pendingNext(
        input logic [PEND_W-1:0] cur,
        input logic [REQ_W-1:0]  add,
        input logic              take
    );
        logic [PEND_W:0] sum;
        sum = {1'b0, cur} + {1'b0, add} - {{PEND_W{1'b0}}, take};
        if (sum > {1'b0, PEND_MAX}) begin
            return PEND_MAX;
        end
        return sum[PEND_W-1:0];
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Bundle of joystick inputs, mode controls and mapped outputs between the
// host side (master) and the mapper (slave).
interface arcade_input_mapper_if
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
);

    logic [JOY_W*NUM_PLAYERS-1:0] joy_i;
    logic                         share_i;
    logic                         coin_on_start_i;
    logic [NUM_PLAYERS-1:0]       af_en_i;
    logic                         mask_i;
    logic [4*NUM_PLAYERS-1:0]     dir_o;
    logic [NUM_PLAYERS-1:0]       fire_o;
    logic [NUM_PLAYERS-1:0]       start_o;
    logic                         coin_o;

    modport master (
        output joy_i, share_i, coin_on_start_i, af_en_i, mask_i,
        input  dir_o, fire_o, start_o, coin_o
    );

    modport slave (
        input  joy_i, share_i, coin_on_start_i, af_en_i, mask_i,
        output dir_o, fire_o, start_o, coin_o
    );

endinterface

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Coin pulse shaper: queues coin requests in a saturating counter and plays
// them out one at a time as a fixed high pulse followed by a fixed low gap.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter logic [COIN_CNT_W-1:0] PULSE_CYC = 16'd4000,
    parameter logic [COIN_CNT_W-1:0] GAP_CYC   = 16'd4000
)(
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [REQ_W-1:0] i_reqCount,
    output logic             o_coin,
    output logic             o_ready
);

    coin_state_t             r_state;
    coin_state_t             w_nextState;
    logic [PEND_W-1:0]       r_pending;
    logic [PEND_W-1:0]       w_nextPending;
    logic [COIN_CNT_W-1:0]   r_cnt;
    logic [COIN_CNT_W-1:0]   w_nextCnt;
    logic                    w_take;
    logic                    r_coin;

    // Next-state logic: leave IDLE by consuming one queued coin, then time the
    // high phase and the low gap with a single shared cycle counter.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            COIN_IDLE: begin
                if (r_pending != '0) begin
                    w_nextState = COIN_HI;
                    w_nextCnt   = '0;
                    w_take      = 1'b1;
                end
            end
            COIN_HI: begin
                if (r_cnt == PULSE_CYC - COIN_CNT_W'(1)) begin
                    w_nextState = COIN_GAP;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + COIN_CNT_W'(1);
                end
            end
            COIN_GAP: begin
                if (r_cnt == GAP_CYC - COIN_CNT_W'(1)) begin
                    w_nextState = COIN_IDLE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + COIN_CNT_W'(1);
                end
            end
            default: begin
                w_nextState = COIN_IDLE;
                w_nextCnt   = '0;
            end
        endcase
        w_nextPending = pendingNext(r_pending, i_reqCount, w_take);
    end

    // State, queue and coin output registers; reset drops any pulse in flight
    // and forgets every queued coin.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state   <= COIN_IDLE;
            r_pending <= '0;
            r_cnt     <= '0;
            r_coin    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pending <= w_nextPending;
            r_cnt     <= w_nextCnt;
            r_coin    <= (w_nextState == COIN_HI);
        end
    end

    assign o_coin  = r_coin;
    assign o_ready = (w_nextState == COIN_IDLE) && (w_nextPending == '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input mapper: masks and registers raw joysticks, maps them onto
// player channels with optional sharing and autofire, and converts coin and
// start presses into shaped coin pulses that always precede their start.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int                    NUM_PLAYERS    = 2,
    parameter logic [COIN_CNT_W-1:0] COIN_PULSE_CYC = 16'd4000,
    parameter logic [COIN_CNT_W-1:0] COIN_GAP_CYC   = 16'd4000,
    parameter logic [AF_CNT_W-1:0]   AF_DIV         = 20'd400000
)(
    input  logic                  clk_sys,
    input  logic                  reset_n,
    arcade_input_mapper_if.slave  io_bus
);

    logic [JOY_W*NUM_PLAYERS-1:0] r_joy;
    logic [JOY_W*NUM_PLAYERS-1:0] r_joyPrev;
    logic [JOY_W-1:0]             w_joyOr;
    logic [JOY_W-1:0]             w_joyOrPrev;
    logic [JOY_W-1:0]             w_joyRise;
    logic [JOY_W-1:0]             w_chan;
    logic [REQ_W-1:0]             w_reqCount;
    logic [AF_CNT_W-1:0]          r_afCnt;
    logic                         r_afPhase;
    logic [4*NUM_PLAYERS-1:0]     w_dirNext;
    logic [4*NUM_PLAYERS-1:0]     r_dir;
    logic [NUM_PLAYERS-1:0]       w_fireNext;
    logic [NUM_PLAYERS-1:0]       r_fire;
    logic [NUM_PLAYERS-1:0]       w_startNext;
    logic [NUM_PLAYERS-1:0]       r_start;
    logic                         w_coinReady;
    logic                         w_coin;
    logic                         w_unused;

    // Input stage: masking happens before the flop so every downstream edge
    // detector sees a clean rise when the mask is released with a button held.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_joy     <= '0;
            r_joyPrev <= '0;
        end else begin
            r_joy     <= io_bus.mask_i ? '0 : io_bus.joy_i;
            r_joyPrev <= r_joy;
        end
    end

    // Merge all joysticks (current and previous) and find rising buttons.
    always_comb begin
        w_joyOr     = '0;
        w_joyOrPrev = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_joyOr     = w_joyOr | r_joy[JOY_W*p +: JOY_W];
            w_joyOrPrev = w_joyOrPrev | r_joyPrev[JOY_W*p +: JOY_W];
        end
        w_joyRise = w_joyOr & ~w_joyOrPrev;
    end

    // Count coin requests this cycle: the coin button plus, optionally, starts.
    always_comb begin
        w_reqCount = '0;
        if (w_joyRise[BIT_COIN]) begin
            w_reqCount = w_reqCount + REQ_W'(1);
        end
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (io_bus.coin_on_start_i && w_joyRise[BIT_START0 + k]) begin
                w_reqCount = w_reqCount + REQ_W'(1);
            end
        end
    end

    // Per-player direction and fire, taken either from the player's own stick
    // or from the merged sticks, with fire gated by the shared autofire phase.
    always_comb begin
        w_dirNext  = '0;
        w_fireNext = '0;
        w_chan     = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_chan = io_bus.share_i ? w_joyOr : r_joy[JOY_W*p +: JOY_W];
            w_dirNext[4*p +: 4] = {w_chan[BIT_U], w_chan[BIT_D], w_chan[BIT_L], w_chan[BIT_R]};
            w_fireNext[p] = w_chan[BIT_FIRE] & (~io_bus.af_en_i[p] | r_afPhase);
        end
    end

    // Starts pass only when no coin is queued or playing, so a game never
    // sees a start before the credit that pays for it.
    always_comb begin
        w_startNext = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            w_startNext[k] = w_joyOr[BIT_START0 + k] & w_coinReady;
        end
    end

    // Free-running autofire divider shared by every player.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_afCnt   <= '0;
            r_afPhase <= 1'b0;
        end else if (r_afCnt == AF_DIV - AF_CNT_W'(1)) begin
            r_afCnt   <= '0;
            r_afPhase <= ~r_afPhase;
        end else begin
            r_afCnt <= r_afCnt + AF_CNT_W'(1);
        end
    end

    // Output stage for directions, fire and starts.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_dir   <= '0;
            r_fire  <= '0;
            r_start <= '0;
        end else begin
            r_dir   <= w_dirNext;
            r_fire  <= w_fireNext;
            r_start <= w_startNext;
        end
    end

    coin_pulser #(
        .PULSE_CYC (COIN_PULSE_CYC),
        .GAP_CYC   (COIN_GAP_CYC)
    ) u_coinPulser (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_reqCount (w_reqCount),
        .o_coin     (w_coin),
        .o_ready    (w_coinReady)
    );

    assign io_bus.dir_o   = r_dir;
    assign io_bus.fire_o  = r_fire;
    assign io_bus.start_o = r_start;
    assign io_bus.coin_o  = w_coin;

    // Spare joystick bits (and starts beyond the player count) are not mapped.
    assign w_unused = ^{w_joyOr, w_joyRise};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for the arcade input mapper: two players, a short coin
// pulse/gap and a fast autofire so every behaviour fits in a few cycles.
module tb_arcade_input_mapper;

    localparam int NP = 2;

    localparam logic [15:0] J_UP     = 16'h0008;
    localparam logic [15:0] J_FIRE   = 16'h0010;
    localparam logic [15:0] J_START0 = 16'h0020;
    localparam logic [15:0] J_START1 = 16'h0040;
    localparam logic [15:0] J_COIN   = 16'h0200;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;

    arcade_input_mapper_if #(.NUM_PLAYERS(NP)) arcadeBus ();

    arcade_input_mapper #(
        .NUM_PLAYERS    (NP),
        .COIN_PULSE_CYC (16'd4),
        .COIN_GAP_CYC   (16'd3),
        .AF_DIV         (20'd2)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .io_bus  (arcadeBus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] joy, input logic share, input logic coinOnStart,
                                 input logic [1:0] afEn, input logic mask);
        arcadeBus.joy_i           = joy;
        arcadeBus.share_i         = share;
        arcadeBus.coin_on_start_i = coinOnStart;
        arcadeBus.af_en_i         = afEn;
        arcadeBus.mask_i          = mask;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCoinRise(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            stepCycles(1);
            if (arcadeBus.coin_o) seen = 1'b1;
        end
    endtask

    // Watches coin_o for a window, optionally toggling a press pattern at the
    // start, and checks each pulse length, each inter-pulse gap and the count.
    task automatic countPulses(input string tag, input int window, input int expected,
                               input int presses, input logic [31:0] pressJoy);
        int pulses  = 0;
        int highRun = 0;
        int lowRun  = 0;
        bit prev    = 1'b0;
        for (int i = 0; i < window; i++) begin
            if (i < 2 * presses) arcadeBus.joy_i = (i % 2 == 0) ? pressJoy : 32'h0;
            else if (i == 2 * presses) arcadeBus.joy_i = 32'h0;
            stepCycles(1);
            if (arcadeBus.coin_o) begin
                if (!prev) begin
                    pulses++;
                    if (pulses > 1) checkOutput({tag, " gap"}, 32'((lowRun >= 3) && (lowRun <= 4)), 32'd1);
                    highRun = 0;
                end
                highRun++;
            end else begin
                if (prev) begin
                    checkOutput({tag, " high"}, highRun, 32'd4);
                    lowRun = 0;
                end
                lowRun++;
            end
            prev = arcadeBus.coin_o;
        end
        checkOutput({tag, " count"}, pulses, expected);
    endtask

    initial begin
        bit          seen;
        int          hi;
        int          align;
        logic [11:0] afSamples;
        logic [7:0]  afGot;

        // Reset with every button pressed: all outputs must stay 0.
        applyStimulus({16'h027F, 16'h027F}, 1'b0, 1'b1, 2'b00, 1'b0);
        reset_n = 1'b0;
        stepCycles(3);
        checkOutput("reset dir", arcadeBus.dir_o, 32'h0);
        checkOutput("reset fire", arcadeBus.fire_o, 32'h0);
        checkOutput("reset start", arcadeBus.start_o, 32'h0);
        checkOutput("reset coin", arcadeBus.coin_o, 32'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(2);
        reset_n = 1'b1;
        stepCycles(3);

        // Direction latency and sharing.
        applyStimulus({16'h0, J_UP}, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(1);
        checkOutput("dir lag1", arcadeBus.dir_o, 32'h00);
        stepCycles(1);
        checkOutput("dir own", arcadeBus.dir_o, 32'h08);
        arcadeBus.share_i = 1'b1;
        stepCycles(2);
        checkOutput("dir share", arcadeBus.dir_o, 32'h88);
        applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(3);

        // Start with no coin coupling follows the merged start level.
        applyStimulus({J_START1, 16'h0}, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(1);
        checkOutput("start lag1", arcadeBus.start_o, 32'h0);
        stepCycles(1);
        checkOutput("start1 plain", arcadeBus.start_o, 32'h2);
        checkOutput("start1 no coin", arcadeBus.coin_o, 32'h0);
        applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(2);
        checkOutput("start1 released", arcadeBus.start_o, 32'h0);

        // Start0 with coin-on-start: 4 high, 3 low, then start appears.
        applyStimulus({16'h0, J_START0}, 1'b0, 1'b1, 2'b00, 1'b0);
        waitCoinRise(10, seen);
        checkOutput("cos rise seen", seen, 32'd1);
        checkOutput("cos start held", arcadeBus.start_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("cos high", arcadeBus.coin_o, 32'd1);
            checkOutput("cos start in high", arcadeBus.start_o, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            checkOutput("cos gap", arcadeBus.coin_o, 32'd0);
            checkOutput("cos start in gap", arcadeBus.start_o, 32'h0);
        end
        stepCycles(1);
        checkOutput("cos start after gap", arcadeBus.start_o, 32'h1);
        applyStimulus(32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
        stepCycles(4);
        checkOutput("cos idle coin", arcadeBus.coin_o, 32'd0);

        // Start0, start1 and coin together: three queued pulses.
        countPulses("triple", 45, 3, 1, {J_START1, J_START0 | J_COIN});
        // Nine requests while the first pulse plays: queue clamps at 7.
        countPulses("saturate", 80, 8, 3, {J_START1, J_START0 | J_COIN});

        // Reset in the middle of a pulse with coins queued.
        arcadeBus.joy_i = {J_START1, J_START0 | J_COIN};
        stepCycles(1);
        arcadeBus.joy_i = 32'h0;
        waitCoinRise(10, seen);
        checkOutput("rst rise seen", seen, 32'd1);
        reset_n = 1'b0;
        stepCycles(1);
        checkOutput("rst coin drop", arcadeBus.coin_o, 32'd0);
        stepCycles(2);
        reset_n = 1'b1;
        countPulses("rst drained", 30, 0, 0, 32'h0);

        // Mask hides a held coin; releasing the mask produces the edge, and
        // re-masking during the pulse does not shorten it.
        applyStimulus({16'h0, J_COIN | J_UP}, 1'b0, 1'b0, 2'b00, 1'b1);
        stepCycles(4);
        checkOutput("mask dir", arcadeBus.dir_o, 32'h0);
        checkOutput("mask coin", arcadeBus.coin_o, 32'd0);
        arcadeBus.mask_i = 1'b0;
        waitCoinRise(10, seen);
        checkOutput("unmask rise seen", seen, 32'd1);
        checkOutput("unmask dir", arcadeBus.dir_o, 32'h08);
        arcadeBus.mask_i = 1'b1;
        hi = 1;
        for (int i = 0; i < 3; i++) begin
            stepCycles(1);
            if (arcadeBus.coin_o) hi++;
        end
        checkOutput("mask hi len", hi, 32'd4);
        stepCycles(1);
        checkOutput("mask gap", arcadeBus.coin_o, 32'd0);
        arcadeBus.joy_i = 32'h0;
        stepCycles(1);
        arcadeBus.mask_i = 1'b0;
        stepCycles(10);
        checkOutput("mask quiet", arcadeBus.coin_o, 32'd0);

        // Autofire on player 0 only, fire held on both.
        applyStimulus({J_FIRE, J_FIRE}, 1'b0, 1'b0, 2'b01, 1'b0);
        stepCycles(4);
        afSamples = '0;
        for (int i = 0; i < 12; i++) begin
            stepCycles(1);
            afSamples[i] = arcadeBus.fire_o[0];
            checkOutput("af fire1 steady", arcadeBus.fire_o[1], 32'd1);
        end
        align = -1;
        for (int a = 4; a >= 1; a--) begin
            if (afSamples[a] && !afSamples[a-1]) align = a;
        end
        checkOutput("af rise found", 32'(align >= 1), 32'd1);
        if (align < 1) align = 1;
        afGot = '0;
        for (int j = 0; j < 8; j++) afGot = {afGot[6:0], afSamples[align + j]};
        checkOutput("af pattern", afGot, 32'hCC);
        applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        stepCycles(3);
        checkOutput("af released", arcadeBus.fire_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
